ifetch_unit: RTL
================

# ifetch_unit

Instruction fetch stage of the single-issue MIPS core, directly upstream of the control decoder. It owns the PC, issues word fetches to instruction memory over a level req/ack handshake, and holds one fetched instruction in an output slot. The slot presents `inst`, `inst_op` (bits 31:26) and `inst_func` (bits 5:0) to the decoder. It accepts branch/jump redirects and a halt request from downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` input 1: single clock, rising edge.
- `rst_b` input 1: synchronous reset, active low.
- `imem_req` output 1: fetch request, level.
- `imem_addr` output 32: word address of the request.
- `imem_ack` input 1: response valid this cycle; meaningful only while `imem_req`=1.
- `imem_rdata` input 32: instruction word, valid with `imem_ack`.
- `stall` input 1: downstream cannot consume the slot this cycle.
- `redirect_valid` input 1: one-cycle pulse, load a new PC.
- `redirect_pc` input 32: target PC.
- `halt_req` input 1: decoder saw the halt encoding.
- `inst_valid` output 1: slot holds an instruction.
- `inst` output 32: slot instruction.
- `inst_op` output 6: `inst[31:26]`.
- `inst_func` output 6: `inst[5:0]`.
- `inst_pc` output 32: PC of slot instruction.
- `halted` output 1: fetch stopped, sticky until reset.
- `fetch_err` output 1: misaligned redirect seen, sticky.

## Operation
- States: FETCH, DRAIN, HALT.
- Reset (`rst_b`=0 at the edge):
  - pc=`RESET_PC`, state=FETCH.
  - All outputs 0: `imem_req`, `inst_valid`, `inst`, `inst_pc`, `halted`, `fetch_err`.
- Slot is consumed in any cycle with `inst_valid`=1 and `stall`=0.
- FETCH:
  - `imem_req`=1 when the slot is empty or being consumed this cycle.
  - Once `imem_req` rises, it and `imem_addr` stay stable until `imem_ack`, regardless of `stall`.
  - On ack: slot loads `imem_rdata` and `inst_pc`=pc, `inst_valid`=1, pc=pc+4.
  - pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Slot consumed with no new ack: `inst_valid` goes to 0 at the next edge.
- `redirect_valid`:
  - Clears `inst_valid` at the next edge and sets pc=`{redirect_pc[31:2],2'b00}`.
  - Request pending without ack this cycle: go to DRAIN.
  - Ack in the same cycle as the redirect: data discarded, stay in FETCH.
- DRAIN:
  - Keep the old request up until ack; discard the data.
  - Then return to FETCH with the redirected pc.
  - A second redirect during DRAIN overwrites pc.
- `halt_req`:
  - Enter HALT: `halted`=1, `inst_valid` cleared.
  - Any pending request drains first, with `imem_req` held until ack and data discarded, then stays low forever.
  - Redirects are ignored once halted.
- Simultaneous `halt_req` and `redirect_valid`: halt wins and pc is not updated.

## Timing
- First `imem_req` is in the first cycle after `rst_b` returns high.
- Ack in cycle N gives `inst_valid`=1 in cycle N+1.
- With `stall`=0 and same-cycle ack, throughput is one instruction per cycle.
- Redirect in cycle N:
  - `inst_valid`=0 in N+1.
  - Request for the target in N+1 if nothing was pending; otherwise the cycle after the drain ack.
- `halted` rises the edge after `halt_req`.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fetch_err`=1 and enters HALT; `halted`=1 in the same edge.
  - pc is not updated.
- Undefined: low bits are silently masked and `fetch_err` is tied 0.

## Structure
- Shared package `ifetch_pkg` holds:
  - state enum `ifetch_state_t` {FETCH, DRAIN, HALT};
  - `PC_STEP`=4;
  - `OP_LSB`=26 and `FUNC_MSB`=5 field constants, also used by the decoder.
- One sub-module, `ifetch_pc_next`: combinational next-PC select (hold / +4 / redirect / mask or error flag).
- The FSM and slot register stay in `ifetch_unit`.

## Test plan
- Reset, zero-wait memory, `stall`=0: `imem_addr` 0, 4, 8 on consecutive cycles; `inst_pc` follows one cycle later.
- Slot full, `stall`=1 for 3 cycles, memory returns 32'h2008_0005: `imem_req` stays 0, `inst`/`inst_pc` held, resume on `stall`=0.
- 2-cycle memory latency, redirect to 32'h40 one cycle after req: old data discarded, `inst_valid` stays 0, next `imem_addr`=32'h40.
- `halt_req` and redirect to 32'h80 in the same cycle: `halted`=1 next cycle, no request to 32'h80, `imem_req` stays 0.
- PC 32'hFFFF_FFFC fetched: the next `imem_addr` is 0.
- With `IFETCH_ALIGN_CHECK_EN`, redirect to 32'h42: `fetch_err`=1 and `halted`=1 next cycle. Without the macro, the next fetch address is 32'h40.

Source files
------------

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared fetch-stage types and instruction field
// positions, also used by the control decoder.
package ifetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } ifetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  localparam int unsigned OP_LSB   = 26;
  localparam int unsigned FUNC_MSB = 5;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction memory level req/ack bus.
// master: fetch side (req, addr out). slave: memory side.
interface ifetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/ifetch_pc_next.sv
// ifetch_pc_next: combinational next-PC select.
// in: pc, advance, redirect, redirect_pc. out: pc_nxt,
// align_err (only with IFETCH_ALIGN_CHECK_EN defined).
module ifetch_pc_next
  import ifetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_nxt,
  output logic        align_err
);

`ifdef IFETCH_ALIGN_CHECK_EN
  assign align_err = redirect &
                     (redirect_pc[1:0] != 2'b00);
`else
  assign align_err = 1'b0;
`endif

  logic sel_err;
  logic sel_redir;
  logic sel_adv;

  // One-hot selects: a redirect beats the sequential step,
  // and a rejected redirect leaves the pc untouched.
  assign sel_err   = align_err;
  assign sel_redir = redirect & ~align_err;
  assign sel_adv   = advance & ~redirect;

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      sel_err:   pc_nxt = pc;
      sel_redir: pc_nxt = word_align(redirect_pc);
      sel_adv:   pc_nxt = pc + PC_STEP;
      default:   pc_nxt = pc;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage; owns pc, fetches over imem
// (ifetch_if.master), holds one slot for the decoder.
// Ports: clk, rst_b (sync, low), imem bus, stall,
// redirect_valid/redirect_pc, halt_req -> inst_valid, inst,
// inst_op, inst_func, inst_pc, halted, fetch_err.
// Option: IFETCH_ALIGN_CHECK_EN traps misaligned redirects.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_b,
  ifetch_if.master        imem,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  input  logic            halt_req,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [5:0]      inst_op,
  output logic [5:0]      inst_func,
  output logic [31:0]     inst_pc,
  output logic            halted,
  output logic            fetch_err
);

  ifetch_state_t state_q;
  ifetch_state_t state_d;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        hold_q;
  logic [31:0] addr_q;
  logic        slot_v_q;
  logic [31:0] slot_inst_q;
  logic [31:0] slot_pc_q;

  logic ack_ok;
  logic consume;
  logic redir_take;
  logic advance;
  logic load;
  logic align_err;
  logic stop;

  assign ack_ok  = imem.imem_req & imem.imem_ack;
  assign consume = slot_v_q & ~stall;

  assign redir_take = redirect_valid &
                      (state_q != HALT) &
                      ~halt_req;

  assign advance = (state_q == FETCH) &
                   ack_ok & ~halt_req;

  // Data arriving alongside a redirect is wrong-path.
  assign load = advance & ~redir_take;

  assign stop = halt_req | align_err;

  ifetch_pc_next u_pc_next (
    .pc          (pc_q),
    .advance     (advance),
    .redirect    (redir_take),
    .redirect_pc (redirect_pc),
    .pc_nxt      (pc_d),
    .align_err   (align_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (stop) begin
          state_d = HALT;
        end else if (redir_take & imem.imem_req &
                     ~imem.imem_ack) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (stop) begin
          state_d = HALT;
        end else if (ack_ok) begin
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // An issued request stays up (hold_q) with its original
  // address until acked, in every state.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = hold_q ? addr_q : pc_q;
    halted         = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem.imem_req = hold_q | ~slot_v_q | ~stall;
      end
      DRAIN: begin
        imem.imem_req = hold_q;
      end
      HALT: begin
        imem.imem_req = hold_q;
        halted        = 1'b1;
      end
      default: begin
        imem.imem_req = 1'b0;
      end
    endcase
    if (!rst_b) begin
      imem.imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      pc_q        <= RESET_PC;
      hold_q      <= 1'b0;
      addr_q      <= 32'd0;
      slot_v_q    <= 1'b0;
      slot_inst_q <= 32'd0;
      slot_pc_q   <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      hold_q <= imem.imem_req & ~imem.imem_ack;
      if (imem.imem_req) begin
        addr_q <= imem.imem_addr;
      end
      if (load) begin
        slot_v_q    <= 1'b1;
        slot_inst_q <= imem.imem_rdata;
        slot_pc_q   <= imem.imem_addr;
      end else if (consume | redirect_valid |
                   halt_req) begin
        slot_v_q <= 1'b0;
      end
    end
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      err_q <= 1'b0;
    end else if (align_err) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign inst_valid = slot_v_q;
  assign inst       = slot_inst_q;
  assign inst_pc    = slot_pc_q;
  assign inst_op    = slot_inst_q[31:OP_LSB];
  assign inst_func  = slot_inst_q[FUNC_MSB:0];

endmodule
